line_mem_responder: RTL and testbench

//   Main-memory responder behind the data cache in the WB stage: the far end of the cache's

---
 rtl/line_mem_responder.sv | 118 +++++++++++
 tb/tb_line_mem_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder for the data cache refill/writeback port.
// Each accepted request completes after a fixed latency with a one-cycle grant.
module line_mem_responder #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 12,
    parameter int LATENCY       = 50
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                mem_rd_req,
    input  logic                                mem_wr_req,
    input  logic [ADDR_LEN-1:0]                 mem_addr,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_wr_line,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_rd_line,
    output logic                                mem_gnt,
    output logic                                mem_busy,
    output logic [31:0]                         rd_cnt,
    output logic [31:0]                         wr_cnt
);
    localparam int WORDS  = 2**LINE_ADDR_LEN;
    localparam int LINE_W = 32*WORDS;
    localparam int DEPTH  = 2**ADDR_LEN;
    localparam int CW     = $clog2(LATENCY) + 1;

    localparam logic [CW-1:0]       LAT_INIT = CW'(LATENCY-2);
    localparam logic [ADDR_LEN-1:0] OFS_MASK = ADDR_LEN'(WORDS-1);
    localparam logic [31:0]         CNT_MAX  = 32'hFFFF_FFFF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       lat_cnt;
    logic                op_wr;
    logic [ADDR_LEN-1:0] base;
    logic [LINE_W-1:0]   wr_buf;
    logic [LINE_W-1:0]   rd_words;
    logic                access;

    logic [31:0] mem [DEPTH];

    // The access edge is the BUSY edge on which the counter has reached zero.
    assign access = (state == BUSY) && (lat_cnt == '0);

    always_comb begin
        rd_words = '0;
        for (int k = 0; k < WORDS; k++)
            rd_words[32*k +: 32] = mem[base | ADDR_LEN'(k)];
    end

    // Storage is never reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && access && op_wr) begin
            for (int k = 0; k < WORDS; k++)
                mem[base | ADDR_LEN'(k)] <= wr_buf[32*k +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            op_wr       <= 1'b0;
            base        <= '0;
            wr_buf      <= '0;
            mem_rd_line <= '0;
            mem_gnt     <= 1'b0;
            mem_busy    <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wr_req) begin
                        op_wr    <= 1'b1;
                        base     <= mem_addr & ~OFS_MASK;
                        wr_buf   <= mem_wr_line;
                        lat_cnt  <= LAT_INIT;
                        state    <= BUSY;
                        mem_busy <= 1'b1;
                    end else if (mem_rd_req) begin
                        op_wr    <= 1'b0;
                        base     <= mem_addr & ~OFS_MASK;
                        lat_cnt  <= LAT_INIT;
                        state    <= BUSY;
                        mem_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (lat_cnt == '0) begin
                        state   <= DONE;
                        mem_gnt <= 1'b1;
                        if (!op_wr)
                            mem_rd_line <= rd_words;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    mem_gnt  <= 1'b0;
                    mem_busy <= 1'b0;
                    if (op_wr) begin
                        if (wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
                    end else begin
                        if (rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_gnt  <= 1'b0;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed table, corner sequences and random traffic
// checked against a word-array memory model with saturating transfer counters.
module tb_line_mem_responder;
    localparam int LAT = 4;
    localparam int LAL = 3;
    localparam int AL  = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rd_req = 1'b0;
    logic         wr_req = 1'b0;
    logic [11:0]  addr = '0;
    logic [255:0] wr_line = '0;
    logic [255:0] rd_line;
    logic         gnt;
    logic         busy;
    logic [31:0]  rd_cnt;
    logic [31:0]  wr_cnt;

    always #5 clk = ~clk;

    line_mem_responder #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .mem_rd_req(rd_req), .mem_wr_req(wr_req),
        .mem_addr(addr), .mem_wr_line(wr_line), .mem_rd_line(rd_line),
        .mem_gnt(gnt), .mem_busy(busy), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0]  mdl [4096];
    bit           mval [4096];
    logic [31:0]  m_rd = '0;
    logic [31:0]  m_wr = '0;
    logic [255:0] m_last = '0;
    bit           m_last_ok = 1'b1;
    logic [11:0]  written [$];

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] base;
        logic [31:0] exp_base;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = b + 32'(k);
        return r;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    function automatic logic [11:0] lbase(input logic [11:0] a);
        return a & 12'hFF8;
    endfunction

    function automatic bit known(input logic [11:0] a);
        bit ok = 1'b1;
        for (int k = 0; k < 8; k++) ok &= mval[lbase(a) + 12'(k)];
        return ok;
    endfunction

    function automatic logic [255:0] model_line(input logic [11:0] a);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = mdl[lbase(a) + 12'(k)];
        return r;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [255:0] line);
        for (int k = 0; k < 8; k++) begin
            mdl[lbase(a) + 12'(k)]  = line[32*k +: 32];
            mval[lbase(a) + 12'(k)] = 1'b1;
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (gnt) break;
        end
    endtask

    // One complete transfer starting from IDLE; returns one cycle after the grant.
    task automatic xfer(input bit wr, input logic [11:0] a, input logic [255:0] line, input string tag);
        int n = 0;
        addr = a;
        if (wr) begin wr_req = 1'b1; wr_line = line; end
        else rd_req = 1'b1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk({tag, " busy"}, 256'(busy), 256'(1));
            if (gnt) break;
        end
        chk({tag, " lat"}, 256'(n), 256'(LAT));
        if (wr) begin
            if (m_last_ok) chk({tag, " rd_line held"}, rd_line, m_last);
            model_write(a, line);
            m_wr = sat(m_wr);
        end else begin
            if (known(a)) begin
                chk({tag, " data"}, rd_line, model_line(a));
                m_last = model_line(a);
                m_last_ok = 1'b1;
            end else begin
                m_last_ok = 1'b0;
            end
            m_rd = sat(m_rd);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, " rd_cnt"}, 256'(rd_cnt), 256'(m_rd));
        chk({tag, " wr_cnt"}, 256'(wr_cnt), 256'(m_wr));
    endtask

    initial begin
        int n;
        logic [255:0] rl;
        logic [11:0]  ra;

        tbl[0] = '{1'b1, 12'h040, 32'hA000_0000, 32'h0};
        tbl[1] = '{1'b0, 12'h045, 32'h0,         32'hA000_0000};
        tbl[2] = '{1'b1, 12'h208, 32'hB000_0000, 32'h0};
        tbl[3] = '{1'b0, 12'h20F, 32'h0,         32'hB000_0000};
        tbl[4] = '{1'b0, 12'h041, 32'h0,         32'hA000_0000};
        tbl[5] = '{1'b1, 12'h040, 32'h1234_5670, 32'h0};
        tbl[6] = '{1'b0, 12'h047, 32'h0,         32'h1234_5670};

        // Reset held with a read pending
        rd_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst gnt",     256'(gnt),    256'(0));
        chk("rst busy",    256'(busy),   256'(0));
        chk("rst rd_line", rd_line,      256'(0));
        chk("rst rd_cnt",  256'(rd_cnt), 256'(0));
        chk("rst wr_cnt",  256'(wr_cnt), 256'(0));
        rst = 1'b1;
        xfer(1'b0, 12'h000, '0, "post-rst read");

        foreach (tbl[i]) begin
            xfer(tbl[i].wr, tbl[i].addr, mk_line(tbl[i].base), $sformatf("tbl%0d", i));
            if (!tbl[i].wr) chk($sformatf("tbl%0d exp", i), rd_line, mk_line(tbl[i].exp_base));
        end
        written.push_back(12'h040);
        written.push_back(12'h208);

        // Simultaneous requests: write first, one IDLE cycle, then the read
        wr_req = 1'b1; rd_req = 1'b1; addr = 12'h080; wr_line = mk_line(32'hC000_0000);
        wait_gnt(n);
        chk("both wr lat", 256'(n), 256'(LAT));
        wr_req = 1'b0;
        model_write(12'h080, mk_line(32'hC000_0000));
        m_wr = sat(m_wr);
        @(posedge clk); #1;
        chk("both idle busy", 256'(busy),   256'(0));
        chk("both wr_cnt",    256'(wr_cnt), 256'(m_wr));
        chk("both rd_cnt",    256'(rd_cnt), 256'(m_rd));
        wait_gnt(n);
        chk("both rd lat", 256'(n), 256'(LAT));
        chk("both rd data", rd_line, mk_line(32'hC000_0000));
        m_rd = sat(m_rd);
        m_last = mk_line(32'hC000_0000);
        m_last_ok = 1'b1;
        rd_req = 1'b0;
        @(posedge clk); #1;
        chk("both rd_cnt2", 256'(rd_cnt), 256'(m_rd));
        written.push_back(12'h080);

        // Address and data changing mid-BUSY are ignored
        xfer(1'b1, 12'h100, mk_line(32'hD000_0000), "pre 0x100");
        wr_req = 1'b1; addr = 12'h180; wr_line = mk_line(32'hE000_0000);
        @(posedge clk); #1;
        addr = 12'h100; wr_line = mk_line(32'hF000_0000);
        wait_gnt(n);
        chk("midbusy lat", 256'(n + 1), 256'(LAT));
        wr_req = 1'b0;
        model_write(12'h180, mk_line(32'hE000_0000));
        m_wr = sat(m_wr);
        @(posedge clk); #1;
        xfer(1'b0, 12'h100, '0, "rd 0x100");
        chk("0x100 unchanged", rd_line, mk_line(32'hD000_0000));
        xfer(1'b0, 12'h180, '0, "rd 0x180");
        chk("0x180 written", rd_line, mk_line(32'hE000_0000));
        written.push_back(12'h100);
        written.push_back(12'h180);

        // Reset mid-write aborts it
        xfer(1'b1, 12'h0C0, mk_line(32'h6000_0000), "pre 0x0C0");
        wr_req = 1'b1; addr = 12'h0C0; wr_line = mk_line(32'h7000_0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("abort gnt%0d", i), 256'(gnt), 256'(0));
        end
        chk("abort busy",    256'(busy),   256'(0));
        chk("abort rd_cnt",  256'(rd_cnt), 256'(0));
        chk("abort wr_cnt",  256'(wr_cnt), 256'(0));
        chk("abort rd_line", rd_line,      256'(0));
        m_rd = '0; m_wr = '0; m_last = '0; m_last_ok = 1'b1;
        rst = 1'b1;
        xfer(1'b0, 12'h0C0, '0, "rd 0x0C0");
        chk("0x0C0 prior", rd_line, mk_line(32'h6000_0000));
        written.push_back(12'h0C0);

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                ra = 12'($urandom);
                for (int k = 0; k < 8; k++) rl[32*k +: 32] = $urandom;
                xfer(1'b1, ra, rl, $sformatf("rnd%0d wr", i));
                written.push_back(lbase(ra));
            end else begin
                ra = written[$urandom_range(written.size() - 1, 0)] | 12'($urandom_range(7, 0));
                xfer(1'b0, ra, '0, $sformatf("rnd%0d rd", i));
            end
        end

        // Read counter saturation
        @(posedge clk); #1;
        force dut.rd_cnt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.rd_cnt;
        m_rd = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) xfer(1'b0, 12'h040, '0, $sformatf("sat%0d", i));
        chk("sat final", 256'(rd_cnt), 256'(32'hFFFF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
